// File: rtl/ast_ldfifo_v2.sv
// ast_ldfifo_v2: circular FIFO with parallel load, non-destructive snapshot and sticky error flags
module ast_ldfifo_v2 #(
    parameter int DEPTH     = 8,
    parameter int DATAWIDTH = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATAWIDTH-1:0]       data_in,
    input  logic                       pop,
    input  logic                       parallel_load,
    input  logic [DEPTH*DATAWIDTH-1:0] array_in,
    input  logic                       snapshot,
    input  logic                       err_clr,
    output logic [DATAWIDTH-1:0]       data_out,
    output logic                       data_valid,
    output logic [DEPTH*DATAWIDTH-1:0] array_out,
    output logic                       snap_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATAWIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]              rd_ptr, wr_ptr;
    logic                       pop_ok, push_ok, ovf_set, udf_set;
    logic [CW-1:0]              count_nxt;
    logic [DEPTH*DATAWIDTH-1:0] snap_arr;

    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign ovf_set   = push & ~push_ok & ~parallel_load;
    assign udf_set   = pop & ~pop_ok & ~parallel_load;
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);

    // Slots beyond the current occupancy read as zero
    always_comb begin
        snap_arr = '0;
        for (int k = 0; k < DEPTH; k++)
            if (CW'(k) < count) snap_arr[k*DATAWIDTH +: DATAWIDTH] = mem[rd_ptr + AW'(k)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            array_out   <= '0;
            snap_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            snap_valid <= 1'b0;
            overflow   <= ovf_set | (overflow & ~err_clr);
            underflow  <= udf_set | (underflow & ~err_clr);
            if (parallel_load) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= array_in[i*DATAWIDTH +: DATAWIDTH];
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= CW'(DEPTH);
                empty       <= 1'b0;
                full        <= 1'b1;
                almost_full <= 1'b1;
            end else begin
                if (push_ok) begin
                    mem[wr_ptr] <= data_in;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    data_out   <= mem[rd_ptr];
                    data_valid <= 1'b1;
                    rd_ptr     <= rd_ptr + 1'b1;
                end
                if (snapshot) begin
                    array_out  <= snap_arr;
                    snap_valid <= 1'b1;
                end
                count       <= count_nxt;
                empty       <= count_nxt == '0;
                full        <= count_nxt == CW'(DEPTH);
                almost_full <= count_nxt >= CW'(AFULL_LVL);
            end
        end
    end
endmodule
